// File: rtl/pulse_period_meter.sv
// pulse_period_meter
// Measures the interval between consecutive rising edges of pulse_in in clk
// cycles. The result uses rate-divider "load" encoding: edges P cycles apart
// report P-1. This matches the value a divider would need to reproduce the
// observed rate.
//
// Optional feature macro: PULSE_PERIOD_METER_SYNC_EN
//   Defined   - pulse_in passes through a two-flop synchroniser (both flops
//               reset to 1) before edge detect. Detection is two cycles later
//               and reported periods are unchanged.
//   Undefined - pulse_in feeds edge detect directly and must be synchronous
//               to clk.
//
// Ports
//   clk        : single clock, rising edge
//   reset_n    : asynchronous active-low reset
//   enable     : measurement enable; low aborts any measurement in progress
//   pulse_in   : pulse stream being measured
//   period_out : last completed measurement (edge-to-edge cycles minus 1)
//   valid      : one-cycle strobe when period_out updates
//   overflow   : last completed measurement saturated
//   measuring  : high while a measurement interval is open
module pulse_period_meter #(
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period_out,
  output logic             valid,
  output logic             overflow,
  output logic             measuring
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             pin;
  logic             pin_d;
  logic             rise;
  logic [WIDTH-1:0] cnt;
  logic             sat;
  logic             cnt_max;

`ifdef PULSE_PERIOD_METER_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  // Flops reset high so an input idling high is not seen as an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= pulse_in;
      sync_q2 <= sync_q1;
    end
  end

  assign pin = sync_q2;
`else
  assign pin = pulse_in;
`endif

  // pin_d resets to 1 so a pulse_in held high out of reset is not an edge.
  // It tracks pin every cycle, independent of enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_d <= 1'b1;
    end else begin
      pin_d <= pin;
    end
  end

  assign rise    = pin & ~pin_d;
  assign cnt_max = &cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // enable low wins over a coincident edge; the first edge opens MEASURE,
  // and later edges keep us there because each edge also starts the next
  // interval.
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else if (state == IDLE && rise) begin
      next_state = MEASURE;
    end
  end

  always_comb begin
    measuring = (state == MEASURE);
  end

  // Counter and result registers. period_out/overflow hold through an abort;
  // only a completed interval updates them. The counter saturates instead of
  // wrapping, and sat remembers that saturation happened in this interval.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      sat        <= 1'b0;
      period_out <= '0;
      overflow   <= 1'b0;
      valid      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        cnt <= '0;
        sat <= 1'b0;
      end else if (state == IDLE) begin
        cnt <= '0;
        sat <= 1'b0;
      end else if (rise) begin
        period_out <= cnt;
        overflow   <= sat | cnt_max;
        valid      <= 1'b1;
        cnt        <= '0;
        sat        <= 1'b0;
      end else if (cnt_max) begin
        sat <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

- Measures the interval between consecutive rising edges of a pulse stream in `clk` cycles.
- Reports the interval in the same "load" encoding the rate divider consumes: a divider loaded with L emits one pulse every L+1 cycles, and this block reports L.
- Sits downstream of any rate divider or external tick source, for self-checking tick generation and for reading an unknown tick rate onto the HEX display path.

## Interface
- `WIDTH`, default 28: counter and result width. 28 bits covers 200M cycles, i.e. 0.25 Hz at 50 MHz.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `enable` input 1: measurement enable. Low aborts any measurement in progress.
- `pulse_in` input 1: pulse stream to measure. A rising edge is one cycle low followed by one cycle high.
- `period_out` output WIDTH: last completed measurement, equal to edge-to-edge cycles minus 1.
- `valid` output 1: one-cycle strobe when `period_out` updates.
- `overflow` output 1: set when the last completed measurement saturated.
- `measuring` output 1: high in state MEASURE.

## Operation
- Edge detect:
  - `pin_d` is a register of the (optionally synchronised) `pulse_in`; `rise = pin & ~pin_d`.
  - `pin_d` resets to 1, so a `pulse_in` held high out of reset is not an edge.
  - `pin_d` updates every cycle regardless of `enable`.
- State IDLE (reset state):
  - `cnt` holds 0.
  - On `enable & rise`: `cnt <= 0`, `sat <= 0`, go to MEASURE. No `valid` on this first edge.
- State MEASURE, no `rise`:
  - `cnt <= cnt + 1` unless `cnt == 2^WIDTH-1`. At that value `cnt` holds (saturates) and `sat <= 1`.
- State MEASURE, on `rise`:
  - `period_out <= cnt`, `overflow <= sat` (or `<= 1` if `cnt` is at max), `valid <= 1`.
  - `cnt <= 0`, `sat <= 0`, stay in MEASURE.
  - This edge also starts the next interval, so measurements are back-to-back with no lost edges.
- `enable` low, any state:
  - Next state IDLE, `cnt <= 0`, `sat <= 0`, `valid <= 0`.
  - `period_out` and `overflow` hold their last values.
- `enable` rising again: a fresh first edge is required before the next measurement.
- `rise` in the same cycle `enable` falls: ignored; `enable` low wins.
- Arithmetic:
  - Unsigned.
  - The increment never wraps; saturation replaces wrap-around.
- Minimum measurable period is 2 cycles, giving `period_out` = 1.
- `pulse_in` stuck high or stuck low after the first edge: `cnt` saturates and no `valid` is issued until a new edge arrives.

## Timing
- Reset values:
  - `period_out` = 0, `overflow` = 0, `valid` = 0, `measuring` = 0.
  - State IDLE, `cnt` = 0, `sat` = 0, `pin_d` = 1, synchroniser flops = 1.
- Latency without the synchroniser:
  - `pulse_in` sampled low at clk edge k-1 and high at edge k gives `rise` at edge k.
  - `period_out`, `overflow` and `valid` update at edge k.
  - `valid` is high for exactly the cycle k..k+1.
- Edges at k and k+P produce `period_out` = P-1 at edge k+P.
- `measuring` rises at the first-edge clock edge and falls at the first clock edge with `enable` sampled low.
- Asynchronous reset mid-measurement:
  - All registers return immediately to reset values.
  - Partial count is discarded and no `valid` is issued.

## Configuration
- `PULSE_PERIOD_METER_SYNC_EN` defined:
  - `pulse_in` passes through a two-flop synchroniser before edge detect.
  - Both flops reset to 1.
  - Detection latency becomes k+2.
  - Reported periods are unchanged.
  - Use this when `pulse_in` comes from a switch or key.
- Undefined:
  - `pulse_in` feeds edge detect directly and must be synchronous to `clk`.
  - Latency as stated under Timing.

## Test plan
- Reset, `enable`=1, single-cycle pulses every 4 cycles for 5 edges -> no `valid` on edge 1; then 4 `valid` strobes each with `period_out`=3, `overflow`=0.
- Rate divider (load 9) driving `pulse_in` from its zero-detect -> `period_out`=9 on every strobe after the first edge.
- `WIDTH`=4, edges 20 cycles apart -> `cnt` saturates at 15, `period_out`=15, `overflow`=1; next edges 6 apart -> `period_out`=5, `overflow`=0.
- Edges every 5 cycles, drop `enable` for 3 cycles mid-interval, re-enable -> no `valid` for the aborted interval; `period_out` holds 4; next `valid` comes only after the second edge following re-enable, with `period_out`=4.
- `pulse_in` held high through reset release, then toggling 1-low/1-high -> no spurious first edge; strobes report `period_out`=1.
- Assert `reset_n` low asynchronously (between clk edges) mid-interval, release -> outputs 0 immediately; the first edge after release produces no `valid`.
